bist_seq_ctrl: RTL and testbench
================================

// Module: bist_seq_ctrl
// PURPOSE
//  Parametrised memory-driven BIST sequencer, successor to the fixed 8-bit/4-bit BIST FSM.
//  Fetches {stimulus, expected} vectors from test ROM over [start_addr..end_addr] and applies each stimulus to the logic under test.
//  Compares each response with the expected value and compacts all responses into a MISR signature.
//  Sits behind the JTAG RUNBIST path; fully single-edge (posedge clk), async active-low reset.
// PARAMETERS
//  ADDR_W    8        test-ROM address width
//  STIM_W    4        stimulus width (ROM word bits [STIM_W+RESP_W-1:RESP_W])
//  RESP_W    4        response/expected width (ROM word bits [RESP_W-1:0])
//  SETTLE    1        extra wait cycles between apply and check (0 allowed)
//  MISR_W    16       signature width, MISR_W >= RESP_W
//  MISR_POLY 16'h1021 MISR feedback polynomial (MISR_W bits)
//  CNT_W     8        fail counter width (saturating)
// PORTS
//  clk             in   1               system clock, all logic on posedge
//  rst_n           in   1               async active-low reset
//  runbist_en      in   1               RUNBIST instruction active
//  idle_en         in   1               TAP in Run-Test/Idle; enabled = runbist_en & idle_en
//  stop_on_fail    in   1               1: end on first mismatch; 0: run full range
//  start_addr      in   ADDR_W          first vector address (latched in INIT)
//  end_addr        in   ADDR_W          last vector address, inclusive (latched in INIT)
//  mem_rd          out  1               ROM read strobe, one cycle
//  mem_addr        out  ADDR_W          ROM address
//  mem_rdata       in   STIM_W+RESP_W   ROM data, valid the cycle after mem_rd
//  dut_stim        out  STIM_W          stimulus to logic under test
//  dut_apply       out  1               one-cycle apply pulse (replaces clogged impact clock)
//  dut_resp        in   RESP_W          response from logic under test
//  busy            out  1               high in any state except IDLE/DONE
//  done            out  1               high in DONE only
//  pass            out  1               done & fail_cnt==0
//  fail_cnt        out  CNT_W           mismatches seen, saturates at all-ones
//  first_fail_addr out  ADDR_W          address of first mismatch
//  first_fail_resp out  RESP_W          response at first mismatch
//  signature       out  MISR_W          MISR content
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; internal addr/latched bounds 0.
//  States: IDLE, INIT, MEM_REQ, MEM_WAIT, APPLY, SETTLE, CHECK, DONE.
//  IDLE -> INIT when enabled.
//  INIT: latch bounds; cur=start; clear fail_cnt, first_fail_*, signature; ->MEM_REQ.
//  INIT, if start>end: ->DONE directly with zero vectors, pass=1.
//  MEM_REQ: mem_rd=1, mem_addr=cur; ->MEM_WAIT.
//  MEM_WAIT: capture mem_rdata into stim/exp regs; ->APPLY.
//  APPLY: dut_apply=1, dut_stim=stim; ->SETTLE (SETTLE>0) else CHECK.
//  SETTLE: count SETTLE cycles; ->CHECK.
//  dut_stim holds from APPLY until the next APPLY.
//  CHECK: sample dut_resp; misr = {misr<<1} ^ (misr[MSB] ? POLY : 0) ^ zext(resp).
//  CHECK, on mismatch: fail_cnt++ (saturating); if first fail, capture cur and resp.
//  CHECK exit: ->DONE if cur==end or (mismatch & stop_on_fail); else cur++ and ->MEM_REQ.
//  Per-vector cost: 4+SETTLE cycles.
//  cur is compared before increment, so end=2^ADDR_W-1 never wraps.
//  DONE: done=1, results frozen; ->IDLE when enabled drops.
//  Abort: enabled low in any state other than IDLE/DONE forces ->IDLE next cycle.
//  On abort: done stays 0; results keep partial values until next INIT; mem_rd/dut_apply drop immediately.
//  start/end changes after INIT are ignored.
//  Re-entry after DONE requires enabled low for at least one cycle.
// TESTING
//  1. start=0,end=3, DUT model echoes expected, SETTLE=1 -> done after 2+4*5 cycles; pass=1; fail_cnt=0; signature = reference MISR.
//  2. start=2,end=5, vector@4 mismatches (exp 4'hA, resp 4'h3), stop_on_fail=1 -> done after 3 vectors; fail_cnt=1; first_fail_addr=4; first_fail_resp=3.
//  3. Same as 2 with stop_on_fail=0 -> all 4 vectors run; fail_cnt=1; signature differs from scenario 1 golden.
//  4. start=8'hFE, end=8'hFF -> exactly 2 ROM reads, no address wrap; done=1.
//  5. start=5, end=4 -> no mem_rd pulse; done=1 two cycles after enabled; pass=1.
//  6. Drop idle_en during SETTLE of vector 2 -> IDLE next cycle, done=0; reassert -> fresh run matches scenario 1.
//  7. Reset asserted mid-run (async) -> all outputs 0 same cycle; fail_cnt saturation checked with CNT_W=2 and 5 fails -> 3.

Source files
------------

// File: rtl/bist_seq_ctrl.sv
// Memory-driven BIST sequencer: fetches {stimulus, expected} vectors from a test ROM,
// applies them to the logic under test, checks each response and compacts it into a MISR.
module bist_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int STIM_W = 4,
  parameter int RESP_W = 4,
  parameter int SETTLE = 1,
  parameter int MISR_W = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 'h1021,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     runbist_en,
  input  logic                     idle_en,
  input  logic                     stop_on_fail,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [STIM_W+RESP_W-1:0] mem_rdata,
  output logic [STIM_W-1:0]        dut_stim,
  output logic                     dut_apply,
  input  logic [RESP_W-1:0]        dut_resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [ADDR_W-1:0]        first_fail_addr,
  output logic [RESP_W-1:0]        first_fail_resp,
  output logic [MISR_W-1:0]        signature
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_MEM_REQ, S_MEM_WAIT, S_APPLY, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cur;
  logic [ADDR_W-1:0]   end_q;
  logic [RESP_W-1:0]   exp_q;
  logic [SCW-1:0]      settle_cnt;
  logic                enabled;
  logic                mismatch;
  logic                last_vec;
  logic                finish;
  logic [MISR_W-1:0]   misr_next;

  assign enabled   = runbist_en & idle_en;
  assign mismatch  = (dut_resp != exp_q);
  assign last_vec  = (cur == end_q);
  assign finish    = last_vec | (mismatch & stop_on_fail);
  assign misr_next = (signature << 1) ^ (signature[MISR_W-1] ? MISR_POLY : '0)
                   ^ MISR_W'(dut_resp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Losing 'enabled' mid-run aborts to IDLE; DONE waits for it to drop so a new run needs a low cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (enabled) state_n = S_INIT;
      S_INIT:     state_n = (start_addr > end_addr) ? S_DONE : S_MEM_REQ;
      S_MEM_REQ:  state_n = S_MEM_WAIT;
      S_MEM_WAIT: state_n = S_APPLY;
      S_APPLY:    state_n = (SETTLE > 0) ? S_SETTLE : S_CHECK;
      S_SETTLE:   if (settle_cnt == SETTLE_LAST) state_n = S_CHECK;
      S_CHECK:    state_n = finish ? S_DONE : S_MEM_REQ;
      S_DONE:     if (!enabled) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    if (!enabled && state != S_IDLE && state != S_DONE) state_n = S_IDLE;
  end

  assign mem_rd    = (state == S_MEM_REQ) & enabled;
  assign dut_apply = (state == S_APPLY) & enabled;
  assign mem_addr  = cur;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign pass      = done && (fail_cnt == '0);

  // Datapath only advances while enabled, so an abort leaves partial results untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur             <= '0;
      end_q           <= '0;
      exp_q           <= '0;
      settle_cnt      <= '0;
      dut_stim        <= '0;
      fail_cnt        <= '0;
      first_fail_addr <= '0;
      first_fail_resp <= '0;
      signature       <= '0;
    end else if (enabled) begin
      case (state)
        S_INIT: begin
          cur             <= start_addr;
          end_q           <= end_addr;
          fail_cnt        <= '0;
          first_fail_addr <= '0;
          first_fail_resp <= '0;
          signature       <= '0;
        end
        S_MEM_WAIT: begin
          dut_stim <= mem_rdata[STIM_W+RESP_W-1:RESP_W];
          exp_q    <= mem_rdata[RESP_W-1:0];
        end
        S_APPLY:  settle_cnt <= '0;
        S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        S_CHECK: begin
          signature <= misr_next;
          if (mismatch) begin
            if (fail_cnt == '0) begin
              first_fail_addr <= cur;
              first_fail_resp <= dut_resp;
            end
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          end
          if (!finish) cur <= cur + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Randomized self-checking bench for bist_seq_ctrl: two instances (default, and SETTLE=0/CNT_W=2)
// run against a ROM + logic-under-test model and a loop-based reference of the BIST outcome.
module tb_bist_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       runbist_en = 1'b0;
  logic       idle_en = 1'b0;
  logic       stop_on_fail = 1'b0;
  logic [7:0] start_addr = '0;
  logic [7:0] end_addr = '0;

  logic       a_mem_rd, a_apply, a_busy, a_done, a_pass;
  logic [7:0] a_mem_addr, a_fail_cnt, a_ffa;
  logic [7:0] a_rdata = '0;
  logic [3:0] a_stim, a_resp, a_ffr;
  logic [15:0] a_sig;

  logic       b_mem_rd, b_apply, b_busy, b_done, b_pass;
  logic [7:0] b_mem_addr, b_ffa;
  logic [1:0] b_fail_cnt;
  logic [7:0] b_rdata = '0;
  logic [3:0] b_stim, b_resp, b_ffr;
  logic [15:0] b_sig;

  logic [7:0] rom [256];
  logic [3:0] resp_tab [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bist_seq_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .runbist_en(runbist_en), .idle_en(idle_en),
    .stop_on_fail(stop_on_fail), .start_addr(start_addr), .end_addr(end_addr),
    .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_rdata(a_rdata),
    .dut_stim(a_stim), .dut_apply(a_apply), .dut_resp(a_resp),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail_cnt(a_fail_cnt),
    .first_fail_addr(a_ffa), .first_fail_resp(a_ffr), .signature(a_sig)
  );

  bist_seq_ctrl #(.SETTLE(0), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .runbist_en(runbist_en), .idle_en(idle_en),
    .stop_on_fail(stop_on_fail), .start_addr(start_addr), .end_addr(end_addr),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
    .dut_stim(b_stim), .dut_apply(b_apply), .dut_resp(b_resp),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail_cnt(b_fail_cnt),
    .first_fail_addr(b_ffa), .first_fail_resp(b_ffr), .signature(b_sig)
  );

  // ROM with one-cycle read latency, and logic under test responding per applied vector
  logic [7:0] a_last = '0, a_applied = '0, b_last = '0, b_applied = '0;
  always @(posedge clk) begin
    if (a_mem_rd) begin a_rdata <= rom[a_mem_addr]; a_last <= a_mem_addr; end
    if (a_apply) a_applied <= a_last;
    if (b_mem_rd) begin b_rdata <= rom[b_mem_addr]; b_last <= b_mem_addr; end
    if (b_apply) b_applied <= b_last;
  end
  assign a_resp = resp_tab[a_applied];
  assign b_resp = resp_tab[b_applied];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Monitors: the k-th read / apply of a run must target start+k
  logic [7:0] run_start = '0;
  int a_rd_idx = 0, a_ap_idx = 0, b_rd_idx = 0, b_ap_idx = 0;
  int a_rd_base = 0, a_ap_base = 0, b_rd_base = 0, b_ap_base = 0;
  always @(negedge clk) begin
    if (a_mem_rd) begin
      checkOutput("a_mem_addr", a_mem_addr, 8'(run_start + (a_rd_idx - a_rd_base)));
      a_rd_idx++;
    end
    if (a_apply) begin
      checkOutput("a_stim", a_stim, rom[8'(run_start + (a_ap_idx - a_ap_base))][7:4]);
      a_ap_idx++;
    end
    if (b_mem_rd) begin
      checkOutput("b_mem_addr", b_mem_addr, 8'(run_start + (b_rd_idx - b_rd_base)));
      b_rd_idx++;
    end
    if (b_apply) begin
      checkOutput("b_stim", b_stim, rom[8'(run_start + (b_ap_idx - b_ap_base))][7:4]);
      b_ap_idx++;
    end
  end

  task automatic refModel(input logic [7:0] s, input logic [7:0] e, input bit stop,
                          input int settle, input int cmax,
                          output int n, output int fails, output int ffa, output int ffr,
                          output logic [15:0] sig, output int cyc);
    logic [3:0] r;
    n = 0; fails = 0; ffa = 0; ffr = 0; sig = '0;
    for (int a = s; a <= e; a++) begin
      n++;
      r = resp_tab[a];
      sig = (sig << 1) ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {12'h000, r};
      if (r != rom[a][3:0]) begin
        if (fails == 0) begin ffa = a; ffr = r; end
        if (fails < cmax) fails++;
        if (stop) break;
      end
    end
    cyc = 2 + n * (4 + settle);
  endtask

  task automatic beginRun(input logic [7:0] s, input logic [7:0] e, input bit stop);
    @(negedge clk);
    run_start = s;
    a_rd_base = a_rd_idx; a_ap_base = a_ap_idx;
    b_rd_base = b_rd_idx; b_ap_base = b_ap_idx;
    start_addr = s; end_addr = e; stop_on_fail = stop;
    runbist_en = 1'b1; idle_en = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] e, input bit stop);
    int an, af, aa, ar, ac, bn, bf, ba, br, bc;
    logic [15:0] asg, bsg;
    int cyc, a_cyc, b_cyc;
    refModel(s, e, stop, 1, 255, an, af, aa, ar, asg, ac);
    refModel(s, e, stop, 0, 3, bn, bf, ba, br, bsg, bc);
    beginRun(s, e, stop);
    cyc = 0; a_cyc = 0; b_cyc = 0;
    while ((a_cyc == 0 || b_cyc == 0) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 2) begin
        start_addr = 8'($urandom);
        end_addr = 8'($urandom);
      end
      if (a_done && a_cyc == 0) a_cyc = cyc;
      if (b_done && b_cyc == 0) b_cyc = cyc;
    end
    checkOutput("a_cycles", a_cyc, ac);
    checkOutput("b_cycles", b_cyc, bc);
    checkOutput("a_pass", a_pass, af == 0);
    checkOutput("a_fail_cnt", a_fail_cnt, af);
    checkOutput("a_first_fail_addr", a_ffa, aa);
    checkOutput("a_first_fail_resp", a_ffr, ar);
    checkOutput("a_signature", a_sig, asg);
    checkOutput("a_reads", a_rd_idx - a_rd_base, an);
    checkOutput("a_busy_done", a_busy, 0);
    checkOutput("b_pass", b_pass, bf == 0);
    checkOutput("b_fail_cnt", b_fail_cnt, bf);
    checkOutput("b_first_fail_addr", b_ffa, ba);
    checkOutput("b_first_fail_resp", b_ffr, br);
    checkOutput("b_signature", b_sig, bsg);
    checkOutput("b_reads", b_rd_idx - b_rd_base, bn);
    runbist_en = 1'b0;
    @(negedge clk);
    checkOutput("a_done_cleared", a_done, 0);
    checkOutput("b_done_cleared", b_done, 0);
  endtask

  task automatic cleanResponses();
    for (int i = 0; i < 256; i++) resp_tab[i] = rom[i][3:0];
  endtask

  logic [15:0] golden1;
  int seen, guard;
  logic [7:0] rs, re;
  int len;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    cleanResponses();

    #3;
    checkOutput("reset_a_outputs", {a_mem_rd, a_mem_addr, a_stim, a_apply, a_busy, a_done, a_pass,
                                    a_fail_cnt, a_ffa, a_ffr, a_sig}, 0);
    checkOutput("reset_b_outputs", {b_mem_rd, b_mem_addr, b_stim, b_apply, b_busy, b_done, b_pass,
                                    b_fail_cnt, b_ffa, b_ffr, b_sig}, 0);
    #10 rst_n = 1'b1;

    $display("[TB] full clean range 0..3");
    applyStimulus(8'd0, 8'd3, 1'b0);
    golden1 = a_sig;

    $display("[TB] mismatch at 4, stop on fail");
    rom[4][3:0] = 4'hA;
    cleanResponses();
    resp_tab[4] = 4'h3;
    applyStimulus(8'd2, 8'd5, 1'b1);
    checkOutput("s2_first_fail_addr", a_ffa, 4);
    checkOutput("s2_first_fail_resp", a_ffr, 3);

    $display("[TB] mismatch at 4, full range");
    applyStimulus(8'd2, 8'd5, 1'b0);
    checkOutput("s3_fail_cnt", a_fail_cnt, 1);
    checkOutput("s3_sig_differs", a_sig != golden1, 1);

    $display("[TB] top of address space");
    applyStimulus(8'hFE, 8'hFF, 1'b0);
    checkOutput("s4_reads", a_rd_idx - a_rd_base, 2);

    $display("[TB] empty range");
    applyStimulus(8'd5, 8'd4, 1'b0);
    checkOutput("s5_reads", a_rd_idx - a_rd_base, 0);

    $display("[TB] abort during settle of vector 2");
    cleanResponses();
    beginRun(8'd0, 8'd3, 1'b0);
    seen = 0; guard = 0;
    while (seen < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (a_apply) seen++;
    end
    checkOutput("abort_reached_apply2", seen, 2);
    @(negedge clk);
    checkOutput("abort_busy_in_settle", a_busy, 1);
    idle_en = 1'b0;
    #1;
    checkOutput("abort_no_strobes", {a_mem_rd, a_apply}, 0);
    @(negedge clk);
    checkOutput("abort_idle", {a_busy, a_done}, 0);
    applyStimulus(8'd0, 8'd3, 1'b0);
    checkOutput("abort_rerun_golden", a_sig, golden1);

    $display("[TB] async reset mid-run");
    beginRun(8'd0, 8'd20, 1'b0);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_a", {a_mem_rd, a_mem_addr, a_stim, a_apply, a_busy, a_done, a_pass,
                                   a_fail_cnt, a_ffa, a_ffr, a_sig}, 0);
    checkOutput("midrun_reset_b", {b_mem_rd, b_mem_addr, b_stim, b_apply, b_busy, b_done, b_pass,
                                   b_fail_cnt, b_ffa, b_ffr, b_sig}, 0);
    runbist_en = 1'b0; idle_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fail counter saturation");
    cleanResponses();
    resp_tab[1] = ~rom[1][3:0];
    resp_tab[2] = ~rom[2][3:0];
    resp_tab[4] = ~rom[4][3:0];
    resp_tab[5] = ~rom[5][3:0];
    resp_tab[7] = ~rom[7][3:0];
    applyStimulus(8'd0, 8'd7, 1'b0);
    checkOutput("sat_b_fail_cnt", b_fail_cnt, 3);
    checkOutput("sat_a_fail_cnt", a_fail_cnt, 5);

    $display("[TB] randomized runs");
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 256; i++) begin
        rom[i] = 8'($urandom);
        resp_tab[i] = rom[i][3:0];
        if ($urandom_range(0, 3) == 0) resp_tab[i] = rom[i][3:0] ^ 4'($urandom_range(1, 15));
      end
      rs = 8'($urandom);
      len = $urandom_range(0, 12);
      if ($urandom_range(0, 5) == 0 && rs > 0) re = rs - 8'd1;
      else re = (int'(rs) + len > 255) ? 8'hFF : 8'(int'(rs) + len);
      applyStimulus(rs, re, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
